// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation codes,
// FSM states and the fixed 32-bit constants used for the divide special cases.
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] MIN_INT  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } funct3T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side bundle for the multiply/divide unit: register-file operands in,
// write-back index/value and pipeline stall out.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            stall;
    logic            busy;
    logic            done;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in,
        input  stall, busy, done, rd_out, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in,
        output stall, busy, done, rd_out, result
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes and result sign on entry,
// result selection and negation on exit, so the datapath stays unsigned.
module muldiv_sign_fix
    import muldiv_unit_pkg::*;
(
    input  logic [2:0]        funct3In,
    input  logic [XLEN-1:0]   opA,
    input  logic [XLEN-1:0]   opB,
    output logic [XLEN-1:0]   magA,
    output logic [XLEN-1:0]   magB,
    output logic              negOut,
    input  logic [2:0]        funct3Run,
    input  logic              negRun,
    input  logic [2*XLEN-1:0] rawIn,
    output logic [XLEN-1:0]   fixedResult
);
    funct3T             opIn;
    funct3T             opRun;
    logic               aSigned;
    logic               bSigned;
    logic               aNeg;
    logic               bNeg;
    logic [2*XLEN-1:0]  prodFix;
    logic [XLEN-1:0]    quo;
    logic [XLEN-1:0]    rem;

    always_comb begin
        opIn    = funct3T'(funct3In);
        aSigned = (opIn == MUL) || (opIn == MULH) || (opIn == MULHSU) ||
                  (opIn == DIV) || (opIn == REM);
        bSigned = (opIn == MUL) || (opIn == MULH) || (opIn == DIV) || (opIn == REM);
        aNeg    = aSigned && opA[XLEN-1];
        bNeg    = bSigned && opB[XLEN-1];
        magA    = aNeg ? -opA : opA;
        magB    = bNeg ? -opB : opB;
        // Remainder follows the dividend; products and quotients take the XOR.
        negOut  = (opIn == REM || opIn == REMU) ? aNeg : (aNeg ^ bNeg);
    end

    always_comb begin
        opRun       = funct3T'(funct3Run);
        prodFix     = negRun ? -rawIn : rawIn;
        quo         = rawIn[XLEN-1:0];
        rem         = rawIn[2*XLEN-1:XLEN];
        fixedResult = '0;
        case (opRun)
            MUL:                 fixedResult = prodFix[XLEN-1:0];
            MULH, MULHSU, MULHU: fixedResult = prodFix[2*XLEN-1:XLEN];
            DIV, DIVU:           fixedResult = negRun ? -quo : quo;
            REM, REMU:           fixedResult = negRun ? -rem : rem;
            default:             fixedResult = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock through a
// single shared 64-bit shift register, stalling the core while it runs.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    import muldiv_unit_pkg::*;

    stateT              stateReg;
    logic [CNT_W-1:0]   cntReg;
    logic [CNT_W-1:0]   cntNext;
    logic [2*XLEN-1:0]  shiftReg;
    logic [XLEN-1:0]    opBReg;
    logic [2:0]         funct3Reg;
    logic               negReg;
    logic               busyReg;
    logic               doneReg;
    logic [4:0]         rdReg;
    logic [XLEN-1:0]    resultReg;

    logic [XLEN-1:0]    magA;
    logic [XLEN-1:0]    magB;
    logic               entryNeg;
    logic [XLEN-1:0]    fixedResult;

    logic [XLEN:0]      mulSum;
    logic [XLEN:0]      divCand;
    logic [XLEN:0]      divDiff;
    logic [2*XLEN-1:0]  mulStep;
    logic [2*XLEN-1:0]  divStep;
    logic [2*XLEN-1:0]  stepNext;
    logic               divByZero;
    logic               signedOvf;
    logic [XLEN-1:0]    specialVal;

    // Exit side sees the post-step value so the last step and fix-up share an edge.
    muldiv_sign_fix u_sign_fix (
        .funct3In    (bus.funct3),
        .opA         (bus.rs1_data),
        .opB         (bus.rs2_data),
        .magA        (magA),
        .magB        (magB),
        .negOut      (entryNeg),
        .funct3Run   (funct3Reg),
        .negRun      (negReg),
        .rawIn       (stepNext),
        .fixedResult (fixedResult)
    );

    always_comb begin
        // Multiply: {hi, lo} with multiplier in lo; add multiplicand to hi, shift right.
        mulSum  = {1'b0, shiftReg[2*XLEN-1:XLEN]} + ({1'b0, opBReg} & {(XLEN+1){shiftReg[0]}});
        mulStep = {mulSum, shiftReg[XLEN-1:1]};
        // Divide: {remainder, quotient} with dividend in lo; restoring subtract.
        divCand = {shiftReg[2*XLEN-1:XLEN], shiftReg[XLEN-1]};
        divDiff = divCand - {1'b0, opBReg};
        if (divDiff[XLEN]) begin
            divStep = {divCand[XLEN-1:0], shiftReg[XLEN-2:0], 1'b0};
        end else begin
            divStep = {divDiff[XLEN-1:0], shiftReg[XLEN-2:0], 1'b1};
        end
        stepNext = funct3Reg[2] ? divStep : mulStep;
        cntNext  = cntReg - 1'b1;
    end

    always_comb begin
        divByZero  = (bus.rs2_data == '0);
        signedOvf  = bus.funct3[2] && !bus.funct3[0] &&
                     (bus.rs1_data == MIN_INT) && (bus.rs2_data == ALL_ONES);
        // funct3[1] separates remainder from quotient for the divide ops.
        if (divByZero) begin
            specialVal = bus.funct3[1] ? bus.rs1_data : ALL_ONES;
        end else begin
            specialVal = bus.funct3[1] ? '0 : MIN_INT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= IDLE;
            cntReg    <= '0;
            shiftReg  <= '0;
            opBReg    <= '0;
            funct3Reg <= '0;
            negReg    <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            rdReg     <= '0;
            resultReg <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    doneReg <= 1'b0;
                    if (bus.start) begin
                        funct3Reg <= bus.funct3;
                        rdReg     <= bus.rd_in;
                        negReg    <= entryNeg;
                        if (bus.funct3[2] && (divByZero || signedOvf)) begin
                            resultReg <= specialVal;
                            doneReg   <= 1'b1;
                            stateReg  <= DONE;
                        end else begin
                            shiftReg <= {{XLEN{1'b0}}, magA};
                            opBReg   <= magB;
                            cntReg   <= CNT_W'(XLEN);
                            busyReg  <= 1'b1;
                            stateReg <= RUN;
                        end
                    end
                end
                RUN: begin
                    shiftReg <= stepNext;
                    cntReg   <= cntNext;
                    if (cntNext == '0) begin
                        resultReg <= fixedResult;
                        busyReg   <= 1'b0;
                        doneReg   <= 1'b1;
                        stateReg  <= DONE;
                    end
                end
                DONE: begin
                    doneReg  <= 1'b0;
                    stateReg <= IDLE;
                end
                default: begin
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall  = (stateReg == IDLE && bus.start) || (stateReg == RUN);
    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
    assign bus.rd_out = rdReg;
    assign bus.result = resultReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, back-to-back and
// reset-abort sequences, then random operations against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic rst;
    int   cycle = 0;
    int   nCompared = 0;
    int   nMismatch = 0;

    muldiv_unit_if mdIf();

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] expRes;
        int          expLat;
    } vecT;

    vecT vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issues one op; lat counts edges from the start-sampling edge to done.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int glitchAt,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat,
                         output int stallCyc, output logic stallInDone,
                         output logic doneAfter, output int doneCyc);
        @(negedge clk);
        mdIf.start    = 1'b1;
        mdIf.funct3   = f3;
        mdIf.rs1_data = a;
        mdIf.rs2_data = b;
        mdIf.rd_in    = rd;
        #1;
        stallCyc = mdIf.stall ? 1 : 0;
        @(posedge clk);
        #1;
        mdIf.start = 1'b0;
        lat = 1;
        while (!mdIf.done && lat < 100) begin
            if (mdIf.stall) stallCyc++;
            if (lat == glitchAt) begin
                mdIf.start    = 1'b1;
                mdIf.funct3   = 3'($urandom);
                mdIf.rs1_data = $urandom;
                mdIf.rs2_data = $urandom;
                mdIf.rd_in    = 5'($urandom);
            end else begin
                mdIf.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        mdIf.start  = 1'b0;
        res         = mdIf.result;
        rdo         = mdIf.rd_out;
        stallInDone = mdIf.stall;
        doneCyc     = cycle;
        @(posedge clk);
        #1;
        doneAfter = mdIf.done;
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          stallCyc;
        logic        stallInDone;
        logic        doneAfter;
        int          doneCyc1;
        int          doneCyc2;
        logic        sawDone;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          mode;

        vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33};
        vecs[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        33};
        vecs[7]  = '{REMU,   32'd100,        32'd7,         5'd12, 32'd2,         33};
        vecs[8]  = '{DIV,    32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{REMU,   32'd5,          32'd0,         5'd14, 32'd5,         1};
        vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
        vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1};
        vecs[12] = '{DIVU,   32'hFFFF_FFFF,  32'd1,         5'd0,  32'hFFFF_FFFF, 33};
        vecs[13] = '{REM,    32'hFFFF_FFFB,  32'd0,         5'd31, 32'hFFFF_FFFB, 1};

        rst           = 1'b1;
        mdIf.start    = 1'b0;
        mdIf.funct3   = 3'b000;
        mdIf.rs1_data = '0;
        mdIf.rs2_data = '0;
        mdIf.rd_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {63'b0, mdIf.busy},  64'd0);
        check("reset done",   {63'b0, mdIf.done},  64'd0);
        check("reset stall",  {63'b0, mdIf.stall}, 64'd0);
        check("reset result", {32'b0, mdIf.result}, 64'd0);
        check("reset rd_out", {59'b0, mdIf.rd_out}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 0,
                  res, rdo, lat, stallCyc, stallInDone, doneAfter, doneCyc1);
            $display("vec%0d f3=%0d a=%h b=%h -> result=%h rd=%0d lat=%0d",
                     i, vecs[i].f3, vecs[i].a, vecs[i].b, res, rdo, lat);
            check($sformatf("vec%0d result", i), {32'b0, res}, {32'b0, vecs[i].expRes});
            check($sformatf("vec%0d rd_out", i), {59'b0, rdo}, {59'b0, vecs[i].rd});
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
            check($sformatf("vec%0d stall cycles", i), 64'(stallCyc), 64'(vecs[i].expLat));
            check($sformatf("vec%0d stall in done", i), {63'b0, stallInDone}, 64'd0);
            check($sformatf("vec%0d done one cycle", i), {63'b0, doneAfter}, 64'd0);
        end

        // Back-to-back with stray start pulses during RUN.
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 5,
              res, rdo, lat, stallCyc, stallInDone, doneAfter, doneCyc1);
        $display("b2b op1 MULHU -> result=%h rd=%0d lat=%0d", res, rdo, lat);
        check("b2b op1 result", {32'b0, res}, 64'hFFFF_FFFE);
        check("b2b op1 rd_out", {59'b0, rdo}, 64'd3);
        issue(DIVU, 32'd100, 32'd7, 5'd4, 12,
              res, rdo, lat, stallCyc, stallInDone, doneAfter, doneCyc2);
        $display("b2b op2 DIVU -> result=%h rd=%0d lat=%0d", res, rdo, lat);
        check("b2b op2 result", {32'b0, res}, 64'd14);
        check("b2b op2 rd_out", {59'b0, rdo}, 64'd4);
        check("b2b done spacing", 64'(doneCyc2 - doneCyc1), 64'd34);

        // Reset in the tenth RUN cycle aborts without a write.
        @(negedge clk);
        mdIf.start    = 1'b1;
        mdIf.funct3   = MUL;
        mdIf.rs1_data = 32'd123;
        mdIf.rs2_data = 32'd456;
        mdIf.rd_in    = 5'd9;
        @(posedge clk);
        #1;
        mdIf.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("abort after reset: busy=%0d stall=%0d result=%h", mdIf.busy, mdIf.stall, mdIf.result);
        check("abort busy",   {63'b0, mdIf.busy},  64'd0);
        check("abort stall",  {63'b0, mdIf.stall}, 64'd0);
        check("abort result", {32'b0, mdIf.result}, 64'd0);
        check("abort rd_out", {59'b0, mdIf.rd_out}, 64'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mdIf.done) sawDone = 1'b1;
        end
        check("abort no done", {63'b0, sawDone}, 64'd0);

        for (int i = 0; i < 150; i++) begin
            f    = 3'($urandom);
            a    = $urandom;
            b    = $urandom;
            rd   = 5'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin
                a = 32'($signed($urandom_range(0, 40)) - 20);
                b = 32'($signed($urandom_range(0, 16)) - 8);
            end
            issue(f, a, b, rd, 0, res, rdo, lat, stallCyc, stallInDone, doneAfter, doneCyc1);
            $display("rnd%0d f3=%0d a=%h b=%h -> result=%h rd=%0d lat=%0d", i, f, a, b, res, rdo, lat);
            check($sformatf("rnd%0d result", i), {32'b0, res}, {32'b0, refModel(f, a, b)});
            check($sformatf("rnd%0d rd_out", i), {59'b0, rdo}, {59'b0, rd});
            check($sformatf("rnd%0d latency", i), 64'(lat), 64'(refLatency(f, a, b)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the register-file read ports and, on completion, drives the register-file write port.
- Asserts a stall so the single-cycle core holds its PC and instruction while an M-extension operation runs.
- Base-ISA ALU ops bypass this block entirely.

Parameters:
- XLEN, 32: operand and result width. Only 32 is supported.
- CNT_W, 6: iteration counter width. Must satisfy 2**CNT_W > XLEN.

Ports:
- clk  input  1  core clock. All state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  decoder flags a valid M-extension instruction this cycle.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  32  operand A, from the register file's first read port.
- rs2_data  input  32  operand B, from the register file's second read port.
- rd_in  input  5  destination register index.
- stall  output  1  combinational; holds PC and instruction fetch.
- busy  output  1  registered; high in RUN.
- done  output  1  registered; one-cycle pulse. Drives the register file's write enable.
- rd_out  output  5  latched destination register index, valid while done=1.
- result  output  32  final value, valid while done=1. Holds its last value otherwise.

Behaviour:
- Clock/reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, internal accumulators=0.
- Reset mid-RUN aborts the operation. No done pulse is produced and no write occurs.
- States: IDLE, RUN, DONE.
- stall = (state==IDLE && start) || state==RUN.
  - stall is 0 in DONE, so the core retires the instruction on the edge that ends DONE.
- IDLE, start=1: latch funct3, rd_in, the operand magnitudes and the result sign.
  - Signedness per funct3: MULHSU treats A as signed and B as unsigned. MULHU, DIVU and REMU treat both as unsigned.
- Special cases go directly to DONE (done 1 edge after start):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_data.
  - Signed overflow, DIV with A=0x80000000 and B=0xFFFFFFFF: quotient 0x80000000, REM 0.
- Otherwise go to RUN with counter=32.
- RUN: one radix-2 step per edge; counter decrements each edge.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract into a 32-bit quotient and 32-bit remainder.
  - When counter reaches 0, apply sign fix-up and load result, then go to DONE.
- Result selection:
  - MUL: low 32 bits of the product. MULH, MULHSU, MULHU: high 32 bits.
  - Quotient takes the XOR of the operand signs. Remainder takes the dividend's sign.
- Latency: done=1 in the cycle following the 33rd rising edge after start is sampled.
- DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE and RUN; operands are not re-latched.
- start asserted in the IDLE cycle immediately after DONE begins a new operation normally (back-to-back).
- rd_in=0: the operation still completes and done still pulses. The register file discards the write to x0.
- All arithmetic is modulo 2^32 on result. Products are exactly 64 bits; no intermediate truncation.

Decomposition:
- Shared package:
  - funct3 encodings (MUL..REMU).
  - State enum (IDLE/RUN/DONE).
  - Constants: XLEN, MIN_INT=0x80000000, ALL_ONES=0xFFFFFFFF.
- One natural sub-module, muldiv_sign_fix: combinational. Performs operand magnitude/sign extraction on entry and result negation on exit. Keeps the FSM/datapath module to a single shared 64-bit shift register.

Test Plan:
- MUL 7 * -3, rd=5: stall high for 33 cycles, then done=1 with result 0xFFFFFFEB and rd_out=5.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 % 7 -> 2. Each reports done exactly 33 edges after start.
- DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 % 0 -> 5, each with done 1 edge after start. DIV 0x80000000 / -1 -> 0x80000000 and REM of the same operands -> 0, each with done 1 edge after start.
- Assert rst at RUN cycle 10: next cycle busy=0, stall=0, result=0. No done pulse in the following 40 cycles.
- Back-to-back sequence: MULHU, then DIVU issued in the first IDLE cycle after DONE. Two done pulses 34 cycles apart, correct results each time. start pulses during RUN are ignored; results are unchanged.
